// File: rtl/aes_bram_port_ctrl_if.sv
// Request/response handshake between the AES top-level controller and the
// BRAM port controller.
interface aes_bram_port_ctrl_if;
    logic        aes_start_read;
    logic        aes_start_write;
    logic [31:0] aes_bram_addr;
    logic [31:0] aes_bram_write_data;
    logic [31:0] aes_bram_read_data;
    logic        bram_complete;
    logic        ctrl_busy;
    logic        ctrl_error;

    modport master (
        output aes_start_read,
        output aes_start_write,
        output aes_bram_addr,
        output aes_bram_write_data,
        input  aes_bram_read_data,
        input  bram_complete,
        input  ctrl_busy,
        input  ctrl_error
    );

    modport slave (
        input  aes_start_read,
        input  aes_start_write,
        input  aes_bram_addr,
        input  aes_bram_write_data,
        output aes_bram_read_data,
        output bram_complete,
        output ctrl_busy,
        output ctrl_error
    );
endinterface

// File: rtl/aes_bram_port_ctrl.sv
// Turns AES start_read/start_write level requests into native single-port BRAM
// cycles, hiding the BRAM read latency behind one uniform complete handshake.
module aes_bram_port_ctrl #(
    parameter int ADDR_WIDTH    = 32,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                    aes_clk,
    input  logic                    aes_rst_n,
    aes_bram_port_ctrl_if.slave     aes_if,
    output logic                    bram_en,
    output logic [3:0]              bram_we,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [31:0]             bram_din,
    input  logic [31:0]             bram_dout
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        WR_ISSUE = 2'd3
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

    state_t                  state_r, state_next_s;
    logic                    rd_prev_r, wr_prev_r;
    logic [3:0]              cnt_r, cnt_next_s;
    logic                    en_r, en_next_s;
    logic [3:0]              we_r, we_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_next_s;
    logic [31:0]             din_r, din_next_s;
    logic [31:0]             rdata_r, rdata_next_s;
    logic                    complete_r, complete_next_s;
    logic                    busy_r, busy_next_s;
    logic                    error_r, error_next_s;

    logic                    rd_edge_s, wr_edge_s, any_edge_s, misaligned_s;
    logic [ADDR_WIDTH-1:0]   aligned_addr_s;

    // Requesters hold start high until complete, so only rising edges count.
    assign rd_edge_s      = aes_if.aes_start_read  & ~rd_prev_r;
    assign wr_edge_s      = aes_if.aes_start_write & ~wr_prev_r;
    assign any_edge_s     = rd_edge_s | wr_edge_s;
    assign misaligned_s   = (aes_if.aes_bram_addr[1:0] != 2'b00);
    assign aligned_addr_s = {aes_if.aes_bram_addr[ADDR_WIDTH-1:2], 2'b00};

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_next_s    = state_r;
        cnt_next_s      = cnt_r;
        en_next_s       = en_r;
        we_next_s       = we_r;
        addr_next_s     = addr_r;
        din_next_s      = din_r;
        rdata_next_s    = rdata_r;
        complete_next_s = 1'b0;
        busy_next_s     = busy_r;
        error_next_s    = error_r;

        case (state_r)
            IDLE: begin
                if (complete_r) begin
                    // Completion cycle still counts as busy: late edges are flagged.
                    busy_next_s  = 1'b0;
                    error_next_s = error_r | any_edge_s;
                end else if (rd_edge_s) begin
                    state_next_s = RD_ISSUE;
                    en_next_s    = 1'b1;
                    we_next_s    = 4'h0;
                    addr_next_s  = aligned_addr_s;
                    din_next_s   = aes_if.aes_bram_write_data;
                    busy_next_s  = 1'b1;
                    error_next_s = error_r | wr_edge_s | misaligned_s;
                end else if (wr_edge_s) begin
                    state_next_s = WR_ISSUE;
                    en_next_s    = 1'b1;
                    we_next_s    = 4'hF;
                    addr_next_s  = aligned_addr_s;
                    din_next_s   = aes_if.aes_bram_write_data;
                    cnt_next_s   = WR_LOAD;
                    busy_next_s  = 1'b1;
                    error_next_s = error_r | misaligned_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_ISSUE: begin
                en_next_s    = 1'b0;
                cnt_next_s   = RD_LOAD;
                state_next_s = RD_WAIT;
                error_next_s = error_r | any_edge_s;
            end
            RD_WAIT: begin
                error_next_s = error_r | any_edge_s;
                if (cnt_r == 4'd0) begin
                    rdata_next_s    = bram_dout;
                    complete_next_s = 1'b1;
                    state_next_s    = IDLE;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            WR_ISSUE: begin
                error_next_s = error_r | any_edge_s;
                if (cnt_r == 4'd0) begin
                    en_next_s       = 1'b0;
                    we_next_s       = 4'h0;
                    complete_next_s = 1'b1;
                    state_next_s    = IDLE;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_next_s = IDLE;
                en_next_s    = 1'b0;
                we_next_s    = 4'h0;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // State, counter, edge history and registered outputs.
    always_ff @(posedge aes_clk or negedge aes_rst_n) begin
        if (!aes_rst_n) begin
            state_r    <= IDLE;
            rd_prev_r  <= 1'b0;
            wr_prev_r  <= 1'b0;
            cnt_r      <= 4'd0;
            en_r       <= 1'b0;
            we_r       <= 4'h0;
            addr_r     <= '0;
            din_r      <= 32'h0;
            rdata_r    <= 32'h0;
            complete_r <= 1'b0;
            busy_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            rd_prev_r  <= aes_if.aes_start_read;
            wr_prev_r  <= aes_if.aes_start_write;
            cnt_r      <= cnt_next_s;
            en_r       <= en_next_s;
            we_r       <= we_next_s;
            addr_r     <= addr_next_s;
            din_r      <= din_next_s;
            rdata_r    <= rdata_next_s;
            complete_r <= complete_next_s;
            busy_r     <= busy_next_s;
            error_r    <= error_next_s;
        end
    end

    assign bram_en                   = en_r;
    assign bram_we                   = we_r;
    assign bram_addr                 = addr_r;
    assign bram_din                  = din_r;
    assign aes_if.aes_bram_read_data = rdata_r;
    assign aes_if.bram_complete      = complete_r;
    assign aes_if.ctrl_busy          = busy_r;
    assign aes_if.ctrl_error         = error_r;

endmodule

// File: doc/aes_bram_port_ctrl.md
Name: aes_bram_port_ctrl

Overview:
- Sits directly downstream of the AES top-level controller and services its word-granular BRAM read/write requests.
- Converts the start_read/start_write level requests and 32-bit byte addresses into native single-port BRAM cycles (en, we, addr, din/dout).
- Returns a one-cycle bram_complete pulse and registered read data.
- Hides BRAM read latency behind a counter-driven state machine so the AES side sees one uniform handshake.

Parameters:
- ADDR_WIDTH, 32, width of the byte address presented to the BRAM port.
- READ_LATENCY, 2, BRAM clock cycles from en to valid dout (legal range 1..15).
- WRITE_LATENCY, 1, cycles the write strobe is held before completion (legal range 1..15).

Ports:
- aes_clk  input  1  single clock; all logic is on the rising edge.
- aes_rst_n  input  1  asynchronous, active-low reset.
- aes_start_read  input  1  read request level from the AES controller.
- aes_start_write  input  1  write request level from the AES controller.
- aes_bram_addr  input  32  byte address of the access.
- aes_bram_write_data  input  32  write word.
- aes_bram_read_data  output  32  registered read word.
- bram_complete  output  1  one-cycle completion pulse.
- ctrl_busy  output  1  high while an access is in flight.
- ctrl_error  output  1  sticky error flag; cleared only by reset.
- bram_en  output  1  BRAM enable.
- bram_we  output  4  BRAM byte write enables (all 4 set or all clear).
- bram_addr  output  ADDR_WIDTH  BRAM byte address, low 2 bits forced to 0.
- bram_din  output  32  BRAM write data.
- bram_dout  input  32  BRAM read data.

Behaviour:
- Reset (async, active-low): state=IDLE; all outputs 0; edge-detect history registers 0; latency counter 0; error cleared.
- Request detection:
  - A request is a rising edge of aes_start_read or aes_start_write, i.e. current level 1 with the previous registered level 0.
  - Held-high levels never retrigger. The requester keeps start high until it sees complete and then drops it, so edge detection is mandatory.
- States:
  - IDLE: on a request, latch addr (bits [1:0] forced 0) and write data, then go to RD_ISSUE or WR_ISSUE. ctrl_busy rises in the same cycle as the transition.
  - RD_ISSUE: bram_en=1 and bram_we=0 for 1 cycle; load counter with READ_LATENCY-1; go to RD_WAIT.
  - RD_WAIT: decrement the counter. At 0, capture bram_dout into aes_bram_read_data, pulse bram_complete, go to IDLE.
  - WR_ISSUE: bram_en=1, bram_we=4'hF, bram_din=latched data, held for WRITE_LATENCY cycles. Then pulse bram_complete, drop en/we, go to IDLE.
- Latency:
  - Request edge to complete is READ_LATENCY+2 cycles for reads and WRITE_LATENCY+1 cycles for writes.
  - ctrl_busy falls in the cycle after the complete pulse.
- aes_bram_read_data holds its value until the next read completes. Writes do not disturb it.
- Simultaneous rising edges on read and write: read is serviced, the write edge is dropped, ctrl_error set.
- Request edge while busy: ignored and ctrl_error set. Edge history still updates.
- Misaligned address (addr[1:0]!=0): access performed at the aligned address, ctrl_error set.
- Request edge arriving in the same cycle as complete: treated as busy, ignored and flagged.
- Reset mid-access: asynchronous abort; en/we drop immediately, no complete pulse is produced, state returns to IDLE.
- Counter width is 4 bits. Out-of-range parameter values are not supported.

Test Plan:
- Read, READ_LATENCY=2, addr 0x0000_0010, BRAM word 0x0000_0004 = 0xDEADBEEF -> bram_addr=0x10; complete exactly 4 cycles after the edge; aes_bram_read_data=0xDEADBEEF.
- Write, addr 0x0000_0104, data 0xCAFEF00D -> one cycle with en=1, we=4'hF, bram_addr=0x104, din=0xCAFEF00D; complete 2 cycles after the edge; read-back returns 0xCAFEF00D.
- Four back-to-back reads at 0x0,0x4,0x8,0xC, with start held high until complete and low for 1 cycle between -> exactly 4 complete pulses and 4 correct words; a start held high for 10 cycles yields no extra accesses.
- Read and write edges in the same cycle -> only a read cycle on the port (we stays 0); ctrl_error=1 and stays 1 until reset.
- Misaligned read at 0x0000_0013 -> bram_addr=0x10; ctrl_error=1; data returned is the word at 0x10.
- aes_rst_n asserted during RD_WAIT -> bram_en=0 immediately; no complete pulse; after release, ctrl_busy=0 and a fresh read completes normally.
